// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 5-stage MIPS core: register/word widths and
// the write-back payload carried by the EX/MEM and MEM/WB registers.
package pipe_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  // Write-back payload as it travels from MEM into WB.
  typedef struct packed {
    logic [XLEN-1:0]  regfile_din;
    logic [REG_W-1:0] wreg;
    logic             regwrite;
    logic [XLEN-1:0]  nextpc;
    logic             int_pc_choose;
    logic [XLEN-1:0]  pc_plus_4;
  } wb_payload_t;

  // A bubble keeps the old payload bits but can never write the register file.
  function automatic wb_payload_t make_bubble(input wb_payload_t p);
    wb_payload_t b;
    b          = p;
    b.regwrite = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/wb_fwd_unit.sv
// Effective write enable and source-operand compare for one forwarding
// source. $0 is hard-wired to zero, so it never writes and never forwards.
module wb_fwd_unit
  import pipe_pkg::*;
(
  input  logic             valid,
  input  logic             regwrite,
  input  logic [REG_W-1:0] wreg,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  output logic             we,
  output logic             rs_hit,
  output logic             rt_hit
);

  // Qualify the write and compare against both EX source registers.
  always_comb begin
    we     = valid & regwrite & (wreg != '0);
    rs_hit = we & (wreg == ex_rs);
    rt_hit = we & (wreg == ex_rt);
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with stall/flush, WB-to-EX forward compare,
// retired-instruction counter and sticky halt flag.
module mem_wb_reg
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_regfile_din,
  input  logic [REG_W-1:0] in_wreg,
  input  logic             in_regwrite,
  input  logic [XLEN-1:0]  in_nextpc,
  input  logic             in_int_pc_choose,
  input  logic [XLEN-1:0]  in_pc_plus_4,
  input  logic             in_halt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_regfile_din,
  output logic [REG_W-1:0] wb_wreg,
  output logic             wb_we,
  output logic [XLEN-1:0]  wb_nextpc,
  output logic [XLEN-1:0]  wb_pc_plus_4,
  output logic             wb_int_pc_choose,
  output logic             fwd_rs_hit,
  output logic             fwd_rt_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted
);

  wb_payload_t      payload_p0;
  wb_payload_t      payload_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] retired_cnt_p1;
  logic             halted_p1;

  always_comb begin
    payload_p0.regfile_din   = in_regfile_din;
    payload_p0.wreg          = in_wreg;
    payload_p0.regwrite      = in_regwrite;
    payload_p0.nextpc        = in_nextpc;
    payload_p0.int_pc_choose = in_int_pc_choose;
    payload_p0.pc_plus_4     = in_pc_plus_4;
  end

  // MEM -> WB boundary: rst > halted > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_p1     <= '0;
      vld_p1         <= 1'b0;
      retired_cnt_p1 <= '0;
      halted_p1      <= 1'b0;
    end else if (halted_p1) begin
      payload_p1     <= payload_p1;
    end else if (flush) begin
      payload_p1     <= make_bubble(payload_p1);
      vld_p1         <= 1'b0;
    end else if (!stall) begin
      payload_p1     <= payload_p0;
      vld_p1         <= in_valid;
      if (in_valid) begin
        retired_cnt_p1 <= retired_cnt_p1 + CNT_W'(1);
        if (in_halt) begin
          halted_p1 <= 1'b1;
        end
      end
    end
  end

  wb_fwd_unit u_fwd (
    .valid    (vld_p1),
    .regwrite (payload_p1.regwrite),
    .wreg     (payload_p1.wreg),
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .we       (wb_we),
    .rs_hit   (fwd_rs_hit),
    .rt_hit   (fwd_rt_hit)
  );

  // Registered state straight out to the WB stage.
  always_comb begin
    wb_valid         = vld_p1;
    wb_regfile_din   = payload_p1.regfile_din;
    wb_wreg          = payload_p1.wreg;
    wb_nextpc        = payload_p1.nextpc;
    wb_pc_plus_4     = payload_p1.pc_plus_4;
    wb_int_pc_choose = payload_p1.int_pc_choose;
    fwd_data         = payload_p1.regfile_din;
    retired_cnt      = retired_cnt_p1;
    halted           = halted_p1;
  end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed bench for mem_wb_reg with a next-state scoreboard.
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_regwrite, in_int_pc_choose, in_halt;
  logic [31:0] in_regfile_din, in_nextpc, in_pc_plus_4;
  logic [4:0]  in_wreg, ex_rs, ex_rt;

  logic        wb_valid, wb_we, wb_int_pc_choose, fwd_rs_hit, fwd_rt_hit, halted;
  logic [31:0] wb_regfile_din, wb_nextpc, wb_pc_plus_4, fwd_data, retired_cnt;
  logic [4:0]  wb_wreg;

  logic        s_valid, s_we, s_int, s_rs_hit, s_rt_hit, s_halted;
  logic [31:0] s_din, s_npc, s_pc4, s_fwd;
  logic [4:0]  s_wreg;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_regfile_din(in_regfile_din), .in_wreg(in_wreg), .in_regwrite(in_regwrite),
    .in_nextpc(in_nextpc), .in_int_pc_choose(in_int_pc_choose),
    .in_pc_plus_4(in_pc_plus_4), .in_halt(in_halt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .wb_valid(wb_valid), .wb_regfile_din(wb_regfile_din), .wb_wreg(wb_wreg),
    .wb_we(wb_we), .wb_nextpc(wb_nextpc), .wb_pc_plus_4(wb_pc_plus_4),
    .wb_int_pc_choose(wb_int_pc_choose), .fwd_rs_hit(fwd_rs_hit),
    .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data), .retired_cnt(retired_cnt),
    .halted(halted)
  );

  mem_wb_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_regfile_din(in_regfile_din), .in_wreg(in_wreg), .in_regwrite(in_regwrite),
    .in_nextpc(in_nextpc), .in_int_pc_choose(in_int_pc_choose),
    .in_pc_plus_4(in_pc_plus_4), .in_halt(in_halt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .wb_valid(s_valid), .wb_regfile_din(s_din), .wb_wreg(s_wreg),
    .wb_we(s_we), .wb_nextpc(s_npc), .wb_pc_plus_4(s_pc4),
    .wb_int_pc_choose(s_int), .fwd_rs_hit(s_rs_hit),
    .fwd_rt_hit(s_rt_hit), .fwd_data(s_fwd), .retired_cnt(s_cnt),
    .halted(s_halted)
  );

  typedef struct {
    logic        valid, we, intsel, rs_hit, rt_hit, halted;
    logic [31:0] din, npc, pc4, cnt;
    logic [4:0]  wreg;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t q[$];

  // Reference state, updated from the operation rules
  logic        m_valid, m_regwrite, m_int, m_halted;
  logic [31:0] m_din, m_npc, m_pc4, m_cnt;
  logic [4:0]  m_wreg;
  logic [3:0]  m_cnt_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    if (rst) begin
      m_valid = 0; m_regwrite = 0; m_int = 0; m_halted = 0;
      m_din = 0; m_npc = 0; m_pc4 = 0; m_cnt = 0; m_wreg = 0; m_cnt_s = 0;
    end else if (m_halted) begin
    end else if (flush) begin
      m_valid = 0; m_regwrite = 0;
    end else if (!stall) begin
      m_valid = in_valid; m_regwrite = in_regwrite; m_int = in_int_pc_choose;
      m_din = in_regfile_din; m_npc = in_nextpc; m_pc4 = in_pc_plus_4; m_wreg = in_wreg;
      if (in_valid) begin
        m_cnt = m_cnt + 1; m_cnt_s = m_cnt_s + 1;
        if (in_halt) m_halted = 1;
      end
    end
    e.valid = m_valid; e.din = m_din; e.wreg = m_wreg; e.npc = m_npc; e.pc4 = m_pc4;
    e.intsel = m_int; e.cnt = m_cnt; e.cnt_s = m_cnt_s; e.halted = m_halted;
    e.we = m_valid && m_regwrite && (m_wreg != 0);
    e.rs_hit = e.we && (m_wreg == ex_rs);
    e.rt_hit = e.we && (m_wreg == ex_rt);
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("wb_valid", 32'(wb_valid), 32'(e.valid));
    chk("wb_regfile_din", wb_regfile_din, e.din);
    chk("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
    chk("wb_we", 32'(wb_we), 32'(e.we));
    chk("wb_nextpc", wb_nextpc, e.npc);
    chk("wb_pc_plus_4", wb_pc_plus_4, e.pc4);
    chk("wb_int_pc_choose", 32'(wb_int_pc_choose), 32'(e.intsel));
    chk("fwd_rs_hit", 32'(fwd_rs_hit), 32'(e.rs_hit));
    chk("fwd_rt_hit", 32'(fwd_rt_hit), 32'(e.rt_hit));
    chk("fwd_data", fwd_data, e.din);
    chk("retired_cnt", retired_cnt, e.cnt);
    chk("halted", 32'(halted), 32'(e.halted));
    chk("small_cnt", 32'(s_cnt), 32'(e.cnt_s));
    chk("small_halted", 32'(s_halted), 32'(e.halted));
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] wr,
                       input logic [31:0] din, input logic h);
    in_valid = v; in_regwrite = rw; in_wreg = wr; in_regfile_din = din; in_halt = h;
    in_nextpc = din ^ 32'hA5A5_0000; in_pc_plus_4 = din + 32'd4;
    in_int_pc_choose = din[0];
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; ex_rs = 0; ex_rt = 0;
    m_halted = 0;
    // Reset with arbitrary inputs
    drive(1, 1, 5'd7, $urandom, 1);
    step();
    drive(1, 1, 5'd3, $urandom, 0);
    step();
    chk("rst_cnt", retired_cnt, 32'd0);
    chk("rst_valid", 32'(wb_valid), 32'd0);
    rst = 0;

    // Load and forward
    ex_rs = 5'd8; ex_rt = 5'd9;
    drive(1, 1, 5'd8, 32'h1234_5678, 0);
    step();
    chk("ld_we", 32'(wb_we), 32'd1);
    chk("ld_rs_hit", 32'(fwd_rs_hit), 32'd1);
    chk("ld_rt_hit", 32'(fwd_rt_hit), 32'd0);
    chk("ld_fwd_data", fwd_data, 32'h1234_5678);
    chk("ld_cnt", retired_cnt, 32'd1);
    ex_rs = 5'd0; ex_rt = 5'd0;
    drive(1, 1, 5'd0, 32'hDEAD_0000, 0);
    step();
    chk("r0_we", 32'(wb_we), 32'd0);
    chk("r0_rs_hit", 32'(fwd_rs_hit), 32'd0);
    chk("r0_rt_hit", 32'(fwd_rt_hit), 32'd0);

    // Stall then flush
    rst = 1; step(); rst = 0;
    ex_rs = 5'd4; ex_rt = 5'd4;
    drive(1, 1, 5'd4, 32'hAAAA_0001, 0);
    step();
    stall = 1;
    drive(1, 1, 5'd5, 32'hBBBB_0002, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_din", wb_regfile_din, 32'hAAAA_0001);
    end
    flush = 1;
    step();
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_we", 32'(wb_we), 32'd0);
    chk("flush_cnt", retired_cnt, 32'd1);
    stall = 0; flush = 0;

    // Bubble carrying regwrite and halt
    drive(0, 1, 5'd6, 32'hCCCC_0003, 1);
    step();
    chk("bub_we", 32'(wb_we), 32'd0);
    chk("bub_halted", 32'(halted), 32'd0);
    chk("bub_cnt", retired_cnt, 32'd1);

    // Halt
    drive(1, 1, 5'd10, 32'h4A17_0010, 1);
    step();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_cnt", retired_cnt, 32'd2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(11 + i), 32'h5000_0000 + 32'(i), 0);
      step();
      chk("halt_frozen_din", wb_regfile_din, 32'h4A17_0010);
      chk("halt_frozen_cnt", retired_cnt, 32'd2);
    end
    rst = 1; step(); rst = 0;
    chk("halt_rst_flag", 32'(halted), 32'd0);
    chk("halt_rst_cnt", retired_cnt, 32'd0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      drive(1, i[0], 5'(i), 32'h7000_0000 + 32'(i), 0);
      step();
      chk("wrap_small_cnt", 32'(s_cnt), 32'((i + 1) % 16));
    end
    chk("wrap_main_cnt", retired_cnt, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
# mem_wb_reg

Pipeline register between the MEM stage and the WB stage of the 5-stage MIPS core. It captures the MEM stage's write-back payload: register-file data, destination register, write enable, next PC, interrupt PC-select and PC+4. It supports stall and flush from the hazard unit and provides a WB-to-EX forwarding compare. It also owns the retired-instruction counter and the sticky halt flag.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (MEM stage frozen)
- flush  in  1  load a bubble instead of the MEM payload
- in_valid  in  1  MEM stage holds a real instruction
- in_regfile_din  in  32  write-back data from MEM
- in_wreg  in  5  destination register number
- in_regwrite  in  1  instruction writes the register file
- in_nextpc  in  32  non-interrupt next PC
- in_int_pc_choose  in  1  interrupt PC-select
- in_pc_plus_4  in  32  PC+4 of the instruction
- in_halt  in  1  instruction is syscall-halt
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
- wb_valid  out  1  WB holds a real instruction
- wb_regfile_din  out  32  registered write-back data
- wb_wreg  out  5  registered destination
- wb_we  out  1  effective write enable = valid & regwrite & (wreg != 0)
- wb_nextpc, wb_pc_plus_4  out  32 each  registered PCs
- wb_int_pc_choose  out  1  registered interrupt select
- fwd_rs_hit, fwd_rt_hit  out  1 each  WB result must be forwarded to EX rs/rt
- fwd_data  out  32  equals wb_regfile_din
- retired_cnt  out  CNT_W  count of instructions entering WB
- halted  out  1  sticky halt flag

## Operation
- Priority per edge: rst > halted > flush > stall > load.
- rst: all registered outputs 0, including wb_valid, retired_cnt and halted.
- halted = 1: register contents frozen, no loads, counter frozen. Only rst clears it.
- flush (halted = 0): wb_valid <- 0 and wb_regwrite <- 0. Other payload fields keep their old values. Counter unchanged. Flush wins over simultaneous stall.
- stall (no flush): every register holds its value. Counter unchanged.
- load (no stall, no flush):
  - All payload fields are captured.
  - wb_valid <- in_valid.
  - If in_valid = 1: retired_cnt <- retired_cnt + 1, modulo 2^CNT_W (wraps to 0). If in_halt = 1 in the same cycle, halted <- 1.
  - If in_valid = 0: in_halt is ignored.
- Combinational outputs:
  - wb_we = wb_valid & wb_regwrite & (wb_wreg != 0).
  - fwd_rs_hit = wb_we & (wb_wreg == ex_rs). fwd_rt_hit is the same for ex_rt.
  - $0 is never forwarded and never written.

## Timing
- Latency: 1 cycle from MEM inputs to wb_* outputs.
- Forward hits are combinational from registered state plus ex_rs/ex_rt. No extra latency.
- The halting instruction itself completes: it is visible in WB with wb_valid = 1, is counted, and sets halted on the same edge. From the next edge on, nothing more is loaded.
- A stall held for N cycles holds the outputs for exactly N cycles. The load happens on the first edge with stall = 0.
- rst asserted mid-stall or mid-halt clears everything on that edge.

## Structure
- Shared package (pipe_pkg): REG_W = 5, XLEN = 32, and a struct type for the MEM/WB payload. The payload is regfile_din, wreg, regwrite, nextpc, int_pc_choose and pc_plus_4. EX/MEM and MEM/WB both reuse this struct.
- One sub-module, wb_fwd_unit: the combinational wb_we and rs/rt compare. It is instantiated once here and is reusable for the EX/MEM forward path.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with arbitrary inputs.
  - Response: all outputs 0, retired_cnt = 0, halted = 0.
- Load and forward:
  - Stimulus: in_valid = 1, regwrite = 1, wreg = 8, din = 0x1234_5678, then ex_rs = 8, ex_rt = 9.
  - Response: next cycle wb_we = 1, fwd_rs_hit = 1, fwd_rt_hit = 0, fwd_data = 0x12345678, retired_cnt = 1.
  - Repeat with wreg = 0: wb_we = 0 and both hits = 0.
- Stall then flush:
  - Stimulus: load instruction A, then stall for 3 cycles while presenting B. Then assert flush and stall together.
  - Response: wb_* shows A for 3 cycles. Then wb_valid = 0, wb_we = 0, counter unchanged at 1.
- Halt:
  - Stimulus: in_valid = 1, in_halt = 1, then 4 more valid instructions.
  - Response: halted = 1 after the first edge, retired_cnt incremented exactly once, wb_* frozen on the halt instruction. rst clears everything.
- Counter wrap:
  - Stimulus: CNT_W = 4; feed 16 valid instructions.
  - Response: retired_cnt runs 1..15, then 0.
- Bubbles:
  - Stimulus: in_valid = 0 with in_regwrite = 1 and in_halt = 1.
  - Response: wb_we = 0, halted = 0, counter unchanged.
